// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds FSM state encodings, widths and the default frame marker.
package imem_loader_pkg;

  localparam int IW = 20;
  localparam int AW = 8;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_B0,
    S_B1,
    S_B2,
    S_CSUM,
    S_ERR_WAIT
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART byte receiver with 2-flop synchronizer and glitch reject.
// Ports: clk, rst, rxd in; data, byte_valid, framing_err out.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic            s1_q, s2_q, s3_q;
  rx_state_t       st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            bv_q, bv_d;
  logic            fe_q, fe_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d  = sh_q;
    bv_d  = 1'b0;
    fe_d  = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (s3_q && !s2_q) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          bv_d  = s2_q;
          fe_d  = !s2_q;
          st_d  = RX_IDLE;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      s3_q  <= 1'b1;
      st_q  <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
      bv_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      s1_q  <= rxd;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      st_q  <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
      bv_q  <= bv_d;
      fe_q  <= fe_d;
    end
  end

  assign data        = sh_q;
  assign byte_valid  = bv_q;
  assign framing_err = fe_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program from UART into instruction RAM, holds CPU.
// Ports: clk, rst, rxd in; we, waddr, wdata, cpu_hold, busy, done, err out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT  = 434,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxd,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [IW-1:0] wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  logic [7:0] rx_data;
  logic       bv;
  logic       fe;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .data       (rx_data),
    .byte_valid (bv),
    .framing_err(fe)
  );

  state_t        state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [3:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [IW-1:0] wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (bv && rx_data == SYNC_BYTE) state_d = S_COUNT;
      S_COUNT:
        if (bv) state_d = S_B0;
      S_B0:
        if (bv) state_d = (rx_data[7:4] != 4'd0) ? S_ERR_WAIT : S_B1;
      S_B1:
        if (bv) state_d = S_B2;
      S_B2:
        if (bv) state_d = (cnt_q == 9'd1) ? S_CSUM : S_B0;
      S_CSUM:
        if (bv) state_d = S_IDLE;
      S_ERR_WAIT:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    if (fe && state_q != S_IDLE && state_q != S_ERR_WAIT)
      state_d = S_ERR_WAIT;
  end

  always_comb begin
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    we_d    = 1'b0;
    // address advances the cycle the write strobe is on the port
    waddr_d = we_q ? waddr_q + 1'b1 : waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (bv && rx_data == SYNC_BYTE) begin
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          waddr_d = '0;
          sum_d   = '0;
        end
      end
      S_COUNT: begin
        if (bv) begin
          // N=0 encodes a full 256-word load
          cnt_d = {rx_data == 8'd0, rx_data};
          sum_d = sum_q + rx_data;
        end
      end
      S_B0: begin
        if (bv) begin
          b0_d  = rx_data[3:0];
          sum_d = sum_q + rx_data;
        end
      end
      S_B1: begin
        if (bv) begin
          b1_d  = rx_data;
          sum_d = sum_q + rx_data;
        end
      end
      S_B2: begin
        if (bv) begin
          we_d    = 1'b1;
          wdata_d = {b0_q, b1_q, rx_data};
          sum_d   = sum_q + rx_data;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_CSUM: begin
        if (bv) begin
          busy_d = 1'b0;
          if (rx_data == sum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (state_d == S_ERR_WAIT && state_q != S_ERR_WAIT) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
      hold_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      sum_q   <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= HOLD_AT_RESET;
    end else begin
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with CLKS_PER_BIT=4.
// Drives UART frames and checks writes and status flags.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        we;
  logic [7:0]  waddr;
  logic [19:0] wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  wa[$];
  logic [19:0] wd[$];

  imem_loader #(.CLKS_PER_BIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && we) begin
      wa.push_back(waddr);
      wd.push_back(wdata);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) @(negedge clk);
    end
    rxd = stop;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic clr;
    wa.delete();
    wd.delete();
  endtask

  task automatic chk_status(input string tag,
                            input logic d,
                            input logic e,
                            input logic h);
    chk({tag, "_done"}, done, d);
    chk({tag, "_err"}, err, e);
    chk({tag, "_hold"}, cpu_hold, h);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"}, we, 1'b0);
    chk({tag, "_waddr"}, waddr, 8'h00);
    chk({tag, "_wdata"}, wdata, 20'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_hold"}, cpu_hold, 1'b1);
  endtask

  logic [7:0] good1[$] = '{8'hA5, 8'h01, 8'h03, 8'h12, 8'h34, 8'h4A};

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single instruction frame
    clr();
    send(good1);
    chk("t1_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t1_addr", wa[0], 8'h00);
      chk("t1_data", wd[0], 20'h31234);
    end
    chk_status("t1", 1'b1, 1'b0, 1'b0);

    // two instructions, boundary values
    clr();
    send('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h01,
           8'h0F, 8'hFF, 8'hFF, 8'h10});
    chk("t2_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("t2_addr0", wa[0], 8'h00);
      chk("t2_data0", wd[0], 20'h00001);
      chk("t2_addr1", wa[1], 8'h01);
      chk("t2_data1", wd[1], 20'hFFFFF);
    end
    chk_status("t2", 1'b1, 1'b0, 1'b0);

    // bad checksum
    clr();
    send('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h01,
           8'h0F, 8'hFF, 8'hFF, 8'h11});
    chk("t3_nwr", wa.size(), 2);
    chk_status("t3", 1'b0, 1'b1, 1'b1);

    // b0 upper nibble nonzero, then recovery
    clr();
    send('{8'hA5, 8'h01, 8'h13, 8'h12, 8'h34, 8'h5A});
    chk("t4_nwr", wa.size(), 0);
    chk_status("t4", 1'b0, 1'b1, 1'b1);
    send(good1);
    chk("t4r_nwr", wa.size(), 1);
    chk_status("t4r", 1'b1, 1'b0, 1'b0);

    // framing error on second instruction byte
    clr();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h03, 1'b1);
    chk("t5_busy_mid", busy, 1'b1);
    chk("t5_hold_mid", cpu_hold, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (4) @(negedge clk);
    chk("t5_nwr", wa.size(), 0);
    chk_status("t5", 1'b0, 1'b1, 1'b1);

    // one-cycle glitch in IDLE, then a sync-looking gap
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (60) @(negedge clk);
    chk("t5g_nwr", wa.size(), 0);
    chk_status("t5g", 1'b0, 1'b1, 1'b1);

    // load one word so waddr is nonzero, then reset mid-frame
    send(good1);
    chk("t6_pre_waddr", waddr, 8'h01);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    chk("t6_busy_mid", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("t6_rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clr();
    send(good1);
    chk("t6_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t6_addr", wa[0], 8'h00);
      chk("t6_data", wd[0], 20'h31234);
    end
    chk_status("t6", 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
